// File: rtl/scm65_pkg.sv
// Shared sizing, types and the write row-select helper for the scm_65 flip-flop memory.
package scm65_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 64;
  localparam int NUM_ROWS   = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  // One bit of the one-hot write decode: row `row` is selected when enabled and addressed.
  function automatic logic row_sel(input int addr, input int row, input logic en);
    return en && (addr == row);
  endfunction

endpackage

// File: rtl/scm_65_if.sv
// Write/read port bundle of scm_65; the memory is the slave, the user drives the master side.
interface scm_65_if
  import scm65_pkg::*;
#(
  parameter int AW = scm65_pkg::ADDR_WIDTH,
  parameter int DW = scm65_pkg::DATA_WIDTH
);
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;
  logic [AW-1:0] RADDR;
  logic [AW-1:0] WADDR;
  logic          RE;
  logic          SE;
  logic          WE;

  modport master (output DIN, RADDR, RE, SE, WADDR, WE, input DOUT);
  modport slave  (input  DIN, RADDR, RE, SE, WADDR, WE, output DOUT);
endinterface

// File: rtl/scm65_row.sv
// One storage row of scm_65. The row clock gate is expressed as a flop enable
// (open on scan, clear or select) so synthesis maps it onto an integrated clock gate.
module scm65_row
  import scm65_pkg::*;
#(
  parameter int DW = scm65_pkg::DATA_WIDTH
) (
  input  logic          CLK,
  input  logic          SE,
  input  logic          sel,
  input  logic          clr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q
);
  logic [DW-1:0] q_q, q_d;
  logic          gate_en;

  // SE opens the gate but data only changes on sel, so scan mode cannot corrupt contents.
  assign gate_en = SE | clr | sel;

  always_comb begin
    q_d = q_q;
    if (sel) q_d = din;
  end

  always_ff @(posedge CLK) begin
    if (clr)          q_q <= '0;
    else if (gate_en) q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/scm_65.sv
// Standard-cell memory: NUM_ROWS x DATA_WIDTH flop array, sync write, combinational read.
// Define SCM65_READ_GATE_EN to force DOUT to zero while RE is low.
module scm_65
  import scm65_pkg::*;
#(
  parameter int ADDR_WIDTH = scm65_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = scm65_pkg::DATA_WIDTH
) (
  input  logic     CLK,
  input  logic     RST,
  scm_65_if.slave  bus
);
  localparam int NROWS = 1 << ADDR_WIDTH;

  logic [NROWS-1:0]                 wsel;
  logic [NROWS-1:0][DATA_WIDTH-1:0] rows;
  logic [DATA_WIDTH-1:0]            rd_word;

  genvar r;
  generate
    for (r = 0; r < NROWS; r++) begin : g_row
      // Reset wins over a write in the same cycle: clear takes priority inside the row.
      assign wsel[r] = row_sel(int'(bus.WADDR), r, bus.WE);

      scm65_row #(.DW(DATA_WIDTH)) u_row (
        .CLK (CLK),
        .SE  (bus.SE),
        .sel (wsel[r]),
        .clr (RST),
        .din (bus.DIN),
        .q   (rows[r])
      );
    end
  endgenerate

  assign rd_word = rows[bus.RADDR];

`ifdef SCM65_READ_GATE_EN
  assign bus.DOUT = bus.RE ? rd_word : '0;
`else
  logic unused_re;
  assign unused_re = bus.RE;
  assign bus.DOUT  = rd_word;
`endif

endmodule

// File: tb/tb_scm_65.sv
// Directed/table-driven check of scm_65: reset, fill, overwrite, same-address, reset priority, idle, scan.
module tb_scm_65;
  import scm65_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  data_t mem_m [NUM_ROWS];

  scm_65_if #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) bus ();

  scm_65 #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  rst;
    logic  we;
    addr_t waddr;
    data_t din;
    addr_t raddr;
    data_t exp;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input data_t act, input data_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at negedge, compare the pre-edge read, then let the edge happen.
  task automatic drive(input logic r, input logic we, input addr_t wa, input data_t d,
                       input logic re, input addr_t ra, input logic se);
    @(negedge clk);
    rst = r; bus.WE = we; bus.WADDR = wa; bus.DIN = d;
    bus.RE = re; bus.RADDR = ra; bus.SE = se;
    #1;
  endtask

  task automatic fill_and_read(input logic se, input string tag);
    for (int i = 0; i < NUM_ROWS; i++) begin
      mem_m[i] = {$urandom, $urandom};
      drive(1'b0, 1'b1, addr_t'(i), mem_m[i], 1'b0, '0, se);
    end
    for (int i = 0; i < NUM_ROWS; i++) begin
      addr_t a;
      a = addr_t'($urandom_range(0, NUM_ROWS-1));
      drive(1'b0, 1'b0, '0, '0, 1'b1, a, se);
      check({tag, "_rand_read"}, bus.DOUT, mem_m[a]);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < NUM_ROWS; i++) mem_m[i] = '0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 6'd8,  64'h8888,                 6'd8,  64'h0};
    tbl[1]  = '{1'b0, 1'b1, 6'd10, 64'h1010,                 6'd8,  64'h8888};
    tbl[2]  = '{1'b0, 1'b1, 6'd9,  64'h9999,                 6'd10, 64'h1010};
    tbl[3]  = '{1'b0, 1'b1, 6'd9,  64'hA5A5,                 6'd9,  64'h9999};
    tbl[4]  = '{1'b0, 1'b0, 6'd0,  64'h0,                    6'd9,  64'hA5A5};
    tbl[5]  = '{1'b0, 1'b0, 6'd0,  64'h0,                    6'd8,  64'h8888};
    tbl[6]  = '{1'b0, 1'b0, 6'd0,  64'h0,                    6'd10, 64'h1010};
    tbl[7]  = '{1'b0, 1'b1, 6'd5,  64'hDEAD_BEEF_0123_4567,  6'd5,  64'h0};
    tbl[8]  = '{1'b0, 1'b1, 6'd5,  64'h1,                    6'd5,  64'hDEAD_BEEF_0123_4567};
    tbl[9]  = '{1'b0, 1'b0, 6'd0,  64'h0,                    6'd5,  64'h1};
    tbl[10] = '{1'b0, 1'b1, 6'd3,  64'h3333,                 6'd3,  64'h0};
    tbl[11] = '{1'b1, 1'b1, 6'd3,  64'hFFFF,                 6'd3,  64'h3333};
    tbl[12] = '{1'b0, 1'b0, 6'd0,  64'h0,                    6'd3,  64'h0};
    tbl[13] = '{1'b0, 1'b0, 6'd0,  64'h0,                    6'd9,  64'h0};
    tbl[14] = '{1'b0, 1'b0, 6'd0,  64'h0,                    6'd5,  64'h0};

    rst = 1'b1; bus.WE = 1'b0; bus.WADDR = '0; bus.DIN = '0;
    bus.RE = 1'b0; bus.RADDR = '0; bus.SE = 1'b0;

    // Reset then sweep every row.
    do_reset();
    for (int i = 0; i < NUM_ROWS; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, addr_t'(i), 1'b0);
      check("reset_row", bus.DOUT, '0);
    end

    fill_and_read(1'b0, "fill");

    // Directed table starting from a cleared array.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].waddr, tbl[i].din, 1'b1, tbl[i].raddr, 1'b0);
      check($sformatf("tbl_%0d", i), bus.DOUT, tbl[i].exp);
    end

    // Idle hold: load a few rows, then WE=RE=0 for 1000 ns.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem_m[i] = 64'h1111_0000_0000_0000 * (i + 1) + 64'(i);
      drive(1'b0, 1'b1, addr_t'(i), mem_m[i], 1'b0, '0, 1'b0);
    end
    for (int c = 0; c < 100; c++) begin
      drive(1'b0, 1'b0, 6'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd2, 1'b0);
      if (c == 50) begin
`ifdef SCM65_READ_GATE_EN
        check("idle_re0_gated", bus.DOUT, '0);
`else
        check("idle_re0_ungated", bus.DOUT, mem_m[2]);
`endif
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, addr_t'(i), 1'b0);
      check("idle_hold", bus.DOUT, mem_m[i]);
    end

    // Scan enable: fill with SE=1, then a single write must leave all other rows alone.
    fill_and_read(1'b1, "se_fill");
    mem_m[7] = 64'h0F0F_F0F0_1234_8765;
    drive(1'b0, 1'b1, 6'd7, mem_m[7], 1'b0, '0, 1'b1);
    for (int i = 0; i < NUM_ROWS; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, addr_t'(i), 1'b1);
      check("se_rows", bus.DOUT, mem_m[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
